// File: rtl/rr_arb_response_router.sv
// Response router for the round-robin arbiter return path.
// A tag FIFO records the one-hot grant of every accepted issue in order.
// The shared resource's in-order responses are then steered to the client
// at the FIFO head through a per-client valid/ready handshake.
module rr_arb_response_router #(
    parameter int NUM_CLIENTS = 4,
    parameter int DEPTH       = 8,
    parameter int DATA_W      = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         issue_valid,
    input  logic [NUM_CLIENTS-1:0]       issue_grant,
    output logic                         issue_ready,
    input  logic                         rsp_valid,
    input  logic [DATA_W-1:0]            rsp_data,
    output logic                         rsp_ready,
    output logic [NUM_CLIENTS-1:0]       cli_rsp_valid,
    output logic [DATA_W-1:0]            cli_rsp_data,
    input  logic [NUM_CLIENTS-1:0]       cli_rsp_ready,
    output logic [$clog2(DEPTH+1)-1:0]   outstanding,
    output logic                         err_unexpected,
    output logic                         err_bad_grant
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [NUM_CLIENTS-1:0] tag_mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic [NUM_CLIENTS-1:0] head;
    logic                   empty;
    logic                   full;
    logic                   grant_onehot;
    logic                   push;
    logic                   pop;

    // Status and handshake terms, all derived from registered FIFO state
    always_comb begin
        empty         = (count == '0);
        full          = (count == CNT_W'(DEPTH));
        grant_onehot  = $onehot(issue_grant);
        head          = tag_mem[rd_ptr];
        issue_ready   = !full;
        cli_rsp_valid = {NUM_CLIENTS{rsp_valid && !empty}} & head;
        cli_rsp_data  = rsp_data;
        rsp_ready     = !empty && (|(head & cli_rsp_ready));
        push          = issue_valid && issue_ready && grant_onehot;
        pop           = rsp_valid && rsp_ready;
        outstanding   = count;
    end

    // Tag storage; contents are only meaningful below the occupancy count
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr] <= issue_grant;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_unexpected <= 1'b0;
            err_bad_grant  <= 1'b0;
        end else begin
            if (rsp_valid && empty) begin
                err_unexpected <= 1'b1;
            end
            if (issue_valid && issue_ready && !grant_onehot) begin
                err_bad_grant <= 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    a_valid_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(cli_rsp_valid));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && empty));
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full));
`endif

endmodule
